chain_sched: RTL and testbench

Sequencer for the anchor-chaining datapath. Reads anchors one at a time from the anchor block memory and keeps a sliding window of the last `WIN` anchors and their chain scores. For each anchor it issues every predecessor pair to the `chain` score unit, reduces the returned candidate scores to the anchor's chain score f[i], and streams f[i] out with ready/valid. It also tracks the best-scoring anchor for the read.

---
 rtl/chain_pkg.sv | 39 +++
 rtl/anchor_hist.sv | 48 ++++
 rtl/chain_sched.sv | 240 ++++++++++++++++++++++++
 tb/tb_chain_sched.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chain_pkg.sv
// chain_pkg: shared definitions for the anchor-chaining sequencer.
//   - state_t      : sequencer FSM encoding (also exported on dbg_state)
//   - X/Y/W_LSB    : bit offsets of the anchor fields inside a memory word
//   - F_MIN        : most negative chain score, the "no best yet" value
//   - anchor_rec_t : one window entry {x, y, f}
//   - smax         : signed maximum used by the score reduction
package chain_pkg;

    localparam int X_LSB   = 0;
    localparam int Y_LSB   = 64;
    localparam int W_LSB   = 80;
    localparam int X_W     = 64;
    localparam int Y_W     = 16;
    localparam int REC_F_W = 32;

    localparam logic [REC_F_W-1:0] F_MIN = {1'b1, {(REC_F_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_ISSUE    = 3'd3,
        S_DRAIN    = 3'd4,
        S_COMMIT   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [REC_F_W-1:0] f;
    } anchor_rec_t;

    function automatic logic [REC_F_W-1:0] smax(input logic [REC_F_W-1:0] a,
                                                input logic [REC_F_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/anchor_hist.sv
// anchor_hist: WIN-deep history of committed anchors.
// Entry age 0 is the most recently pushed anchor (j = i-1), age WIN-1 the
// oldest. A push shifts every entry one age older and drops the oldest.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : synchronous clear of every entry (start of a run)
//   push         : insert push_rec at age 0
//   push_rec     : record to insert
//   rd_age       : age to read; ages >= WIN read as all zeros
//   rd_rec       : combinational read data for rd_age
module anchor_hist
    import chain_pkg::*;
#(
    parameter int WIN   = 8,
    parameter int AGE_W = $clog2(WIN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  anchor_rec_t       push_rec,
    input  logic [AGE_W-1:0]  rd_age,
    output anchor_rec_t       rd_rec
);

    anchor_rec_t hist [WIN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < WIN; k++) hist[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < WIN; k++) hist[k] <= '0;
        end else if (push) begin
            hist[0] <= push_rec;
            for (int k = 1; k < WIN; k++) hist[k] <= hist[k-1];
        end
    end

    // Compare-based mux so that an out-of-range age returns zero instead
    // of indexing past the array.
    always_comb begin
        rd_rec = '0;
        for (int k = 0; k < WIN; k++) begin
            if (AGE_W'(k) == rd_age) rd_rec = hist[k];
        end
    end

endmodule

// File: rtl/chain_sched.sv
// chain_sched: sequencer for the anchor-chaining datapath.
// For each anchor i it fetches the anchor word, issues one candidate pair per
// cycle against the last min(i, WIN) committed anchors, max-reduces the
// returned scores with the anchor's seed weight into f[i], hands f[i] out on
// a ready/valid port and pushes it into the history window. The best f over
// the run is tracked with ties keeping the earlier index.
//
// Handshake: res_valid/res_ready follow strict valid/ready rules -- once
// res_valid is high, res_idx/res_f are held and res_valid stays high until
// the cycle where res_ready is also high; that cycle is the transfer.
//
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   start, num_anchors     : run request (IDLE only), anchor count
//   busy, done             : run in progress, one-cycle end-of-run pulse
//   mem_en, mem_addr,
//   mem_dout               : anchor memory read port, 1-cycle read latency
//   cand_*                 : registered pair to the score unit
//   score_valid, score     : in-order candidate scores, latency >= 1
//   res_valid, res_ready,
//   res_idx, res_f         : per-anchor chain score stream
//   best_f, best_idx       : best anchor of the run, held until next start
//   dbg_state              : current FSM state (state_t encoding)
//
// Timing: the last pair's score may land in the first COMMIT cycle; the
// returned value is folded combinationally into res_f so that with score
// latency 1 an anchor with WIN predecessors takes 11 cycles.
module chain_sched
    import chain_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int WIN    = 8,
    parameter int F_W    = REC_F_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_anchors,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [159:0]      mem_dout,
    output logic              cand_valid,
    output logic [63:0]       cand_xi,
    output logic [63:0]       cand_xj,
    output logic [15:0]       cand_yi,
    output logic [15:0]       cand_yj,
    output logic [F_W-1:0]    cand_fj,
    input  logic              score_valid,
    input  logic [F_W-1:0]    score,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_idx,
    output logic [F_W-1:0]    res_f,
    output logic [F_W-1:0]    best_f,
    output logic [ADDR_W-1:0] best_idx,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = $clog2(WIN + 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   i_q;
    logic [ADDR_W:0]   i_nxt;
    logic [63:0]       cur_x;
    logic [15:0]       cur_y;
    logic [F_W-1:0]    acc_q;
    logic [F_W-1:0]    acc_merged;
    logic [CNT_W-1:0]  p_q;
    logic [CNT_W-1:0]  p_new;
    logic [CNT_W-1:0]  k_q;        // age of the pair currently on cand_*
    logic [CNT_W-1:0]  k_nxt;
    logic [CNT_W-1:0]  cnt_q;      // scores still outstanding
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ret;
    logic              issue_last;
    logic              last_anchor;
    logic              res_valid_c;
    logic              hs;
    logic              cand_valid_q;
    logic [63:0]       cand_xi_q, cand_xj_q;
    logic [15:0]       cand_yi_q, cand_yj_q;
    logic [F_W-1:0]    cand_fj_q;
    logic [F_W-1:0]    best_f_q;
    logic [ADDR_W-1:0] best_idx_q;
    logic [CNT_W-1:0]  rd_age;
    anchor_rec_t       rd_rec;
    anchor_rec_t       push_rec;
    logic              hist_clr;
    logic              unused_mem_bits;

    assign unused_mem_bits = ^mem_dout[159:112];

    // A return with nothing outstanding is dropped without side effects,
    // which also discards stale returns after a reset.
    assign ret         = score_valid && (cnt_q != '0);
    // cand_valid is high exactly in ISSUE, so it doubles as the issue strobe.
    assign cnt_nxt     = cnt_q + CNT_W'(cand_valid_q) - CNT_W'(ret);
    assign acc_merged  = ret ? smax(acc_q, score) : acc_q;
    assign k_nxt       = k_q + CNT_W'(1);
    assign issue_last  = (k_nxt >= p_q);
    assign i_nxt       = i_q + (ADDR_W+1)'(1);
    assign last_anchor = (i_nxt == n_q);
    assign p_new       = (i_q >= (ADDR_W+1)'(WIN)) ? CNT_W'(WIN) : CNT_W'(i_q);
    assign hs          = res_valid_c && res_ready;

    // Age 0 feeds the first pair while the anchor word arrives; in ISSUE the
    // next age is prefetched for the following cycle.
    assign rd_age   = (state_q == S_ISSUE) ? k_nxt : '0;
    assign push_rec = '{x: cur_x, y: cur_y, f: acc_merged};
    assign hist_clr = (state_q == S_IDLE) && start;

    anchor_hist #(.WIN(WIN), .AGE_W(CNT_W)) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr      (hist_clr),
        .push     (hs),
        .push_rec (push_rec),
        .rd_age   (rd_age),
        .rd_rec   (rd_rec)
    );

    always_comb begin
        state_d     = state_q;
        res_valid_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = (num_anchors == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH:    state_d = S_WAIT_MEM;
            S_WAIT_MEM: state_d = (p_new == '0) ? S_COMMIT : S_ISSUE;
            S_ISSUE: begin
                // At most one score (the last pair's) may still be in flight
                // on entry to COMMIT; it is folded in when it lands.
                if (issue_last) state_d = (cnt_nxt <= CNT_W'(1)) ? S_COMMIT : S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_nxt <= CNT_W'(1)) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                res_valid_c = (cnt_nxt == '0);
                if (res_valid_c && res_ready) state_d = last_anchor ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            i_q          <= '0;
            cur_x        <= '0;
            cur_y        <= '0;
            acc_q        <= '0;
            p_q          <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            cand_valid_q <= 1'b0;
            cand_xi_q    <= '0;
            cand_xj_q    <= '0;
            cand_yi_q    <= '0;
            cand_yj_q    <= '0;
            cand_fj_q    <= '0;
            best_f_q     <= '0;
            best_idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_nxt;
            acc_q   <= acc_merged;

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q        <= num_anchors;
                        i_q        <= '0;
                        best_idx_q <= '0;
                        best_f_q   <= (num_anchors == '0) ? '0 : F_MIN;
                    end
                end
                S_WAIT_MEM: begin
                    cur_x <= mem_dout[X_LSB +: X_W];
                    cur_y <= mem_dout[Y_LSB +: Y_W];
                    acc_q <= mem_dout[W_LSB +: F_W];
                    p_q   <= p_new;
                    k_q   <= '0;
                    if (p_new != '0) begin
                        cand_valid_q <= 1'b1;
                        cand_xi_q    <= mem_dout[X_LSB +: X_W];
                        cand_yi_q    <= mem_dout[Y_LSB +: Y_W];
                        cand_xj_q    <= rd_rec.x;
                        cand_yj_q    <= rd_rec.y;
                        cand_fj_q    <= rd_rec.f;
                    end
                end
                S_ISSUE: begin
                    if (issue_last) begin
                        cand_valid_q <= 1'b0;
                    end else begin
                        k_q       <= k_nxt;
                        cand_xj_q <= rd_rec.x;
                        cand_yj_q <= rd_rec.y;
                        cand_fj_q <= rd_rec.f;
                    end
                end
                S_COMMIT: begin
                    if (hs) begin
                        i_q <= i_nxt;
                        if ($signed(acc_merged) > $signed(best_f_q)) begin
                            best_f_q   <= acc_merged;
                            best_idx_q <= i_q[ADDR_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign mem_en     = (state_q == S_FETCH);
    assign mem_addr   = i_q[ADDR_W-1:0];
    assign cand_valid = cand_valid_q;
    assign cand_xi    = cand_xi_q;
    assign cand_xj    = cand_xj_q;
    assign cand_yi    = cand_yi_q;
    assign cand_yj    = cand_yj_q;
    assign cand_fj    = cand_fj_q;
    assign res_valid  = res_valid_c;
    assign res_idx    = i_q[ADDR_W-1:0];
    assign res_f      = acc_merged;
    assign best_f     = best_f_q;
    assign best_idx   = best_idx_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_chain_sched.sv
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_chain_sched;
    import chain_pkg::*;

    localparam int ADDR_W = 6;
    localparam int WIN    = 8;
    localparam int F_W    = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [ADDR_W:0]   num_anchors = '0;
    logic              busy, done, mem_en, cand_valid, res_valid;
    logic              res_ready = 1'b1;
    logic [ADDR_W-1:0] mem_addr, res_idx, best_idx;
    logic [159:0]      mem_dout = '0;
    logic [63:0]       cand_xi, cand_xj;
    logic [15:0]       cand_yi, cand_yj;
    logic [F_W-1:0]    cand_fj, res_f, best_f;
    logic              score_valid = 1'b0;
    logic [F_W-1:0]    score = '0;
    logic [2:0]        dbg_state;

    chain_sched #(.ADDR_W(ADDR_W), .WIN(WIN), .F_W(F_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_anchors(num_anchors),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .cand_valid(cand_valid), .cand_xi(cand_xi),
        .cand_xj(cand_xj), .cand_yi(cand_yi), .cand_yj(cand_yj),
        .cand_fj(cand_fj), .score_valid(score_valid), .score(score),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_f(res_f), .best_f(best_f), .best_idx(best_idx),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- anchor memory ----------------
    logic [159:0] mem [0:63];
    int           f_tab [0:63];

    function automatic logic [63:0] ax(input int i);
        return 64'h0123_0000_0000_0000 + 64'(i) * 64'h0000_0001_0000_0101;
    endfunction

    function automatic logic [15:0] ay(input int i);
        return 16'(i * 3 + 1);
    endfunction

    task automatic load_mem(input int w);
        for (int i = 0; i < 64; i++) begin
            mem[i] = {48'hDEAD_BEEF_CAFE, 32'(w), ay(i), ax(i)};
        end
    endtask

    always @(posedge clk) begin
        if (mem_en) mem_dout <= mem[mem_addr];
    end

    // ---------------- score unit model ----------------
    int             lat  = 1;
    int             mode = 0;    // 0: f_j + 2, 1: constant -100
    logic           pipe_v [0:7];
    logic [F_W-1:0] pipe_s [0:7];

    always begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                pipe_v[k] = 1'b0;
                pipe_s[k] = '0;
            end
            score_valid = 1'b0;
            score       = '0;
        end else begin
            #1;
            if (rst) begin
                for (int k = 7; k > 0; k--) begin
                    pipe_v[k] = pipe_v[k-1];
                    pipe_s[k] = pipe_s[k-1];
                end
                pipe_v[0] = cand_valid;
                pipe_s[0] = (mode == 0) ? cand_fj + 32'd2 : 32'hFFFF_FF9C;
                score_valid = pipe_v[lat];
                score       = pipe_s[lat];
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [ADDR_W+F_W-1:0] exp_q [$];
    logic [ADDR_W+F_W-1:0] e;
    int                    pair_cnt   = 0;
    int                    total_cand = 0;
    int                    fetch_cnt  = 0;
    int                    jj;
    logic                  prev_stall = 1'b0;
    logic [ADDR_W-1:0]     prev_idx;
    logic [F_W-1:0]        prev_f;

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), F_W'(f_tab[i])});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pair_cnt   = 0;
            prev_stall = 1'b0;
        end else begin
            if (mem_en) fetch_cnt++;
            if (prev_stall) begin
                `CHK("stall_valid", res_valid, 1'b1)
                `CHK("stall_idx", res_idx, prev_idx)
                `CHK("stall_f", res_f, prev_f)
                `CHK("stall_no_fetch", mem_en, 1'b0)
            end
            if (cand_valid) begin
                jj = int'(res_idx) - 1 - pair_cnt;
                `CHK("cand_xi", cand_xi, ax(int'(res_idx)))
                `CHK("cand_yi", cand_yi, ay(int'(res_idx)))
                `CHK("cand_j_in_range", (jj >= 0), 1'b1)
                if (jj >= 0) begin
                    `CHK("cand_xj", cand_xj, ax(jj))
                    `CHK("cand_yj", cand_yj, ay(jj))
                    `CHK("cand_fj", cand_fj, F_W'(f_tab[jj]))
                end
                pair_cnt++;
                total_cand++;
            end
            prev_stall = res_valid && !res_ready;
            prev_idx   = res_idx;
            prev_f     = res_f;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL res_unexpected observed idx=%0d f=%0h expected=none", res_idx, res_f);
                end else begin
                    e = exp_q.pop_front();
                    `CHK("res", {res_idx, res_f}, e)
                    `CHK("pairs", pair_cnt, (int'(res_idx) >= WIN) ? WIN : int'(res_idx))
                end
                pair_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int n);
        @(posedge clk);
        #1;
        num_anchors = (ADDR_W+1)'(n);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        `CHK(tag, done, 1'b1)
    endtask

    task automatic wait_for(input string tag, input int budget,
                            input logic [2:0] st, input int idx, input logic want_fetch);
        int cyc;
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (want_fetch) hit = mem_en && (int'(mem_addr) == idx);
            else            hit = (dbg_state == st) && (int'(res_idx) == idx) && res_valid == (st == S_COMMIT);
        end
        `CHK(tag, hit, 1'b1)
    endtask

    task automatic setup_run(input int w, input int md, input int l, input int n);
        load_mem(w);
        mode = md;
        lat  = l;
        for (int i = 0; i < 64; i++) f_tab[i] = 0;
        for (int i = 0; i < n; i++) f_tab[i] = (md == 0) ? (w + 2 * i) : w;
        fetch_cnt  = 0;
        total_cand = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset state
        #12;
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_mem_en", mem_en, 1'b0)
        `CHK("rst_cand_valid", cand_valid, 1'b0)
        `CHK("rst_res_valid", res_valid, 1'b0)
        `CHK("rst_best", {best_f, best_idx}, '0)
        `CHK("rst_state", dbg_state, 3'(S_IDLE))
        @(posedge clk);
        #1 rst = 1'b1;

        // single anchor, w=5
        setup_run(5, 0, 1, 1);
        push_exp(1);
        pulse_start(1);
        wait_done("single_done", 100);
        `CHK("single_best_f", best_f, 32'd5)
        `CHK("single_best_idx", best_idx, 6'd0)
        `CHK("single_no_pairs", total_cand, 0)
        `CHK("single_drained", exp_q.size(), 0)

        // zero anchors: done the cycle after start, best cleared, no traffic
        setup_run(5, 0, 1, 0);
        @(posedge clk);
        #1;
        num_anchors = '0;
        start       = 1'b1;
        @(negedge clk);
        `CHK("zero_done_not_early", done, 1'b0)
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        `CHK("zero_done", done, 1'b1)
        `CHK("zero_busy", busy, 1'b0)
        `CHK("zero_best_f", best_f, 32'd0)
        `CHK("zero_best_idx", best_idx, 6'd0)
        @(negedge clk);
        `CHK("zero_done_pulse", done, 1'b0)
        `CHK("zero_no_fetch", fetch_cnt, 0)
        `CHK("zero_no_pairs", total_cand, 0)

        // twelve anchors, score = f_j + 2, latency 3
        setup_run(1, 0, 3, 12);
        push_exp(12);
        pulse_start(12);
        wait_done("twelve_done", 1000);
        `CHK("twelve_best_idx", best_idx, 6'd11)
        `CHK("twelve_best_f", best_f, 32'd23)
        `CHK("twelve_fetches", fetch_cnt, 12)
        `CHK("twelve_pairs", total_cand, 60)
        `CHK("twelve_drained", exp_q.size(), 0)

        // negative scores: every f is the seed weight, tie keeps index 0
        setup_run(4, 1, 2, 12);
        push_exp(12);
        pulse_start(12);
        wait_done("neg_done", 1000);
        `CHK("neg_best_idx", best_idx, 6'd0)
        `CHK("neg_best_f", best_f, 32'd4)
        `CHK("neg_drained", exp_q.size(), 0)

        // backpressure at anchor 3
        setup_run(1, 0, 1, 12);
        push_exp(12);
        pulse_start(12);
        wait_for("bp_fetch3", 200, S_FETCH, 3, 1'b1);
        @(posedge clk);
        #1 res_ready = 1'b0;
        wait_for("bp_commit3", 200, S_COMMIT, 3, 1'b0);
        repeat (5) @(negedge clk);
        `CHK("bp_still_idx3", res_idx, 6'd3)
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_done("bp_done", 1000);
        `CHK("bp_best_idx", best_idx, 6'd11)
        `CHK("bp_best_f", best_f, 32'd23)
        `CHK("bp_fetches", fetch_cnt, 12)
        `CHK("bp_drained", exp_q.size(), 0)

        // reset during DRAIN of anchor 6, then a clean rerun
        setup_run(1, 0, 3, 12);
        push_exp(12);
        pulse_start(12);
        wait_for("mid_drain6", 1000, S_DRAIN, 6, 1'b0);
        #1 rst = 1'b0;
        #1;
        `CHK("mid_busy", busy, 1'b0)
        `CHK("mid_done", done, 1'b0)
        `CHK("mid_mem", {mem_en, mem_addr}, '0)
        `CHK("mid_cand", {cand_valid, cand_xi, cand_xj, cand_yi, cand_yj, cand_fj}, '0)
        `CHK("mid_res", {res_valid, res_idx, res_f}, '0)
        `CHK("mid_best", {best_f, best_idx}, '0)
        `CHK("mid_state", dbg_state, 3'(S_IDLE))
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        setup_run(1, 0, 3, 12);
        push_exp(12);
        pulse_start(12);
        wait_done("rerun_done", 1000);
        `CHK("rerun_best_idx", best_idx, 6'd11)
        `CHK("rerun_best_f", best_f, 32'd23)
        `CHK("rerun_pairs", total_cand, 60)
        `CHK("rerun_drained", exp_q.size(), 0)

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
